// File: rtl/nn_pkg.sv
// Shared types and constants for the argmax output-decision stage.
// Also holds fixed-point conversion helpers used by benches.
package nn_pkg;

  localparam int WIDTH       = 16;
  localparam int FRAC        = 8;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [WIDTH-1:0] score_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [NUM_CLASSES-1:0]  onehot_t;

  function automatic onehot_t onehot_of(idx_t i);
    return onehot_t'(1) << i;
  endfunction

  function automatic score_t real_to_fixed(real r);
    real s;
    s = r * real'(1 << FRAC);
    s = (s < 0.0) ? s - 0.5 : s + 0.5;
    return score_t'($rtoi(s));
  endfunction

  function automatic real fixed_to_real(score_t v);
    return $itor(v) / real'(1 << FRAC);
  endfunction

endpackage

// File: rtl/nn_argmax_classifier_if.sv
// Score-vector input and class-result output handshakes.
// slave is the classifier side, master the network/consumer side.
interface nn_argmax_classifier_if;
  import nn_pkg::*;

  logic    in_valid;
  logic    in_ready;
  score_t  net_output1;
  score_t  net_output2;
  score_t  net_output3;
  score_t  net_output4;
  score_t  net_output5;
  score_t  net_output6;
  score_t  net_output7;
  score_t  net_output8;
  score_t  net_output9;
  score_t  net_output10;
  logic    out_valid;
  logic    out_ready;
  idx_t    class_idx;
  onehot_t class_onehot;
  score_t  max_value;
  logic    confident;

  modport slave (
    input  in_valid,
    input  net_output1, net_output2,
    input  net_output3, net_output4,
    input  net_output5, net_output6,
    input  net_output7, net_output8,
    input  net_output9, net_output10,
    input  out_ready,
    output in_ready,
    output out_valid,
    output class_idx,
    output class_onehot,
    output max_value,
    output confident
  );

  modport master (
    output in_valid,
    output net_output1, net_output2,
    output net_output3, net_output4,
    output net_output5, net_output6,
    output net_output7, net_output8,
    output net_output9, net_output10,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  class_idx,
    input  class_onehot,
    input  max_value,
    input  confident
  );

endinterface

// File: rtl/nn_max_cmp.sv
// Signed compare-and-select of one candidate against the running best.
// Strict greater-than, so an equal later candidate never displaces it.
module nn_max_cmp
  import nn_pkg::*;
(
  input  score_t cand_val,
  input  idx_t   cand_idx,
  input  score_t best_val,
  input  idx_t   best_idx,
  output score_t sel_val,
  output idx_t   sel_idx
);

  logic take;

  assign take    = cand_val > best_val;
  assign sel_val = take ? cand_val : best_val;
  assign sel_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/nn_argmax_classifier.sv
// Argmax over ten signed scores, one comparison per clock.
// Result is registered and held until the consumer accepts it.
module nn_argmax_classifier
  import nn_pkg::*;
#(
  parameter score_t CONF_THRESH = '0
) (
  input  logic clk,
  input  logic rst,
  nn_argmax_classifier_if.slave bus
);

  state_t state;
  score_t sbuf [NUM_CLASSES];
  score_t best_val;
  idx_t   best_idx;
  idx_t   scan_idx;
  score_t cand;
  score_t sel_val;
  idx_t   sel_idx;
  logic   finalize;

  assign finalize = scan_idx == IDX_W'(NUM_CLASSES);

  always_comb begin
    cand = best_val;
    if (!finalize) cand = sbuf[scan_idx];
  end

  nn_max_cmp u_cmp (
    .cand_val (cand),
    .cand_idx (scan_idx),
    .best_val (best_val),
    .best_idx (best_idx),
    .sel_val  (sel_val),
    .sel_idx  (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      best_val         <= '0;
      best_idx         <= '0;
      scan_idx         <= '0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.class_idx    <= '0;
      bus.class_onehot <= '0;
      bus.max_value    <= '0;
      bus.confident    <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++)
        sbuf[i] <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.in_valid && bus.in_ready) begin
            sbuf[0]      <= bus.net_output1;
            sbuf[1]      <= bus.net_output2;
            sbuf[2]      <= bus.net_output3;
            sbuf[3]      <= bus.net_output4;
            sbuf[4]      <= bus.net_output5;
            sbuf[5]      <= bus.net_output6;
            sbuf[6]      <= bus.net_output7;
            sbuf[7]      <= bus.net_output8;
            sbuf[8]      <= bus.net_output9;
            sbuf[9]      <= bus.net_output10;
            best_val     <= bus.net_output1;
            best_idx     <= '0;
            scan_idx     <= IDX_W'(1);
            bus.in_ready <= 1'b0;
            state        <= SCAN;
          end
        end
        (state == SCAN): begin
          if (finalize) begin
            // best_* already reflects all ten entries here
            bus.class_idx    <= best_idx;
            bus.class_onehot <= onehot_of(best_idx);
            bus.max_value    <= best_val;
            bus.confident    <= best_val > CONF_THRESH;
            bus.out_valid    <= 1'b1;
            state            <= DONE;
          end else begin
            best_val <= sel_val;
            best_idx <= sel_idx;
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        (state == DONE): begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            scan_idx      <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Scoreboard bench for nn_argmax_classifier.
// Driver pushes expected results; monitor pops on each new out_valid.
module tb_nn_argmax_classifier;
  import nn_pkg::*;

  typedef struct {
    idx_t    idx;
    onehot_t oh;
    score_t  val;
    logic    conf;
    time     t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntot = 0;
  int   nfail = 0;
  bit   seen = 1'b0;
  exp_t q [$];

  always #5 clk = ~clk;

  nn_argmax_classifier_if ifc ();

  nn_argmax_classifier #(.CONF_THRESH(16'sd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input score_t v [NUM_CLASSES]);
    ifc.net_output1  = v[0];
    ifc.net_output2  = v[1];
    ifc.net_output3  = v[2];
    ifc.net_output4  = v[3];
    ifc.net_output5  = v[4];
    ifc.net_output6  = v[5];
    ifc.net_output7  = v[6];
    ifc.net_output8  = v[7];
    ifc.net_output9  = v[8];
    ifc.net_output10 = v[9];
  endtask

  task automatic send(input score_t v [NUM_CLASSES],
                      input exp_t e, input bit track);
    int n;
    exp_t x;
    @(negedge clk);
    set_vec(v);
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    x = e;
    x.t = $time;
    if (track) q.push_back(x);
    #1 ifc.in_valid = 1'b0;
  endtask

  function automatic exp_t mk(idx_t i, score_t v, logic c);
    exp_t e;
    e.idx  = i;
    e.oh   = onehot_of(i);
    e.val  = v;
    e.conf = c;
    e.t    = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (ifc.out_valid && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("class_idx", 32'(ifc.class_idx), 32'(e.idx));
          chk("class_onehot", 32'(ifc.class_onehot), 32'(e.oh));
          chk("max_value", 32'(ifc.max_value), 32'(e.val));
          chk("confident", 32'(ifc.confident), 32'(e.conf));
          chk("latency", 32'(($time - e.t - 5) / 10), 32'd10);
        end
      end
      if (ifc.out_valid && ifc.out_ready) seen = 1'b0;
    end
  end

  initial begin
    score_t v [NUM_CLASSES];
    score_t w [NUM_CLASSES];
    real    r [NUM_CLASSES];
    int     n;
    int     best;
    exp_t   e;

    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < NUM_CLASSES; i++) v[i] = '0;
    set_vec(v);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_class_idx", 32'(ifc.class_idx), 32'd0);
    chk("rst_onehot", 32'(ifc.class_onehot), 32'd0);
    chk("rst_max_value", 32'(ifc.max_value), 32'd0);
    chk("rst_confident", 32'(ifc.confident), 32'd0);
    rst = 1'b0;

    v = '{16'hFF80, 16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00,
          16'hFB00, 16'hFA00, 16'hF900, 16'hF800, 16'h0200};
    send(v, mk(4'd9, 16'h0200, 1'b1), 1'b1);

    for (int i = 0; i < NUM_CLASSES; i++) v[i] = 16'hF000;
    v[2] = 16'hFF80;
    v[6] = 16'hFF80;
    send(v, mk(4'd2, 16'hFF80, 1'b0), 1'b1);

    for (int i = 0; i < NUM_CLASSES; i++) v[i] = 16'h8000;
    send(v, mk(4'd0, 16'h8000, 1'b0), 1'b1);

    for (int i = 0; i < NUM_CLASSES; i++) v[i] = 16'h0000;
    send(v, mk(4'd0, 16'h0000, 1'b0), 1'b1);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) v[i] = 16'h0000;
    v[4] = 16'h7FFF;
    send(v, mk(4'd4, 16'h7FFF, 1'b1), 1'b1);
    n = 0;
    while (!ifc.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", 32'(ifc.out_valid), 32'd1);
    for (int i = 0; i < NUM_CLASSES; i++) w[i] = 16'h0100;
    w[7] = 16'h0500;
    set_vec(w);
    ifc.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_class_idx", 32'(ifc.class_idx), 32'd4);
      chk("bp_max_value", 32'(ifc.max_value), 32'h7FFF);
    end
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1 ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(ifc.out_valid), 32'd0);
    for (int i = 0; i < NUM_CLASSES; i++) v[i] = 16'h0000;
    v[0] = 16'h0001;
    send(v, mk(4'd0, 16'h0001, 1'b1), 1'b1);

    v = '{16'hFF80, 16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00,
          16'hFB00, 16'hFA00, 16'hF900, 16'hF800, 16'h0200};
    send(v, mk(4'd9, 16'h0200, 1'b1), 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("abort_out_valid", 32'(ifc.out_valid), 32'd0);
    rst = 1'b0;
    repeat (15) @(posedge clk);

    r = '{0.0746, 0.8037, -0.25, 0.1, 0.3,
          -0.9, 0.5, 0.05, 0.7, 1.1875};
    for (int i = 0; i < NUM_CLASSES; i++) v[i] = real_to_fixed(r[i]);
    best = 0;
    for (int i = 1; i < NUM_CLASSES; i++)
      if (fixed_to_real(v[i]) > fixed_to_real(v[best])) best = i;
    chk("e2e_label", 32'(best), 32'd9);
    e = mk(idx_t'(best), v[best], fixed_to_real(v[best]) > 0.0);
    send(v, e, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
